// File: rtl/intdiv_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master supplies operands and accepts results; the slave is the divider.
interface intdiv_seq_if #(
   parameter int LOG_A = 64,
   parameter int LOG_B = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [LOG_A-1:0] A;
   logic [LOG_B-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [LOG_A-1:0] Q;
   logic [LOG_B-1:0] R;
   logic             div_by_zero;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, Q, R, div_by_zero
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, Q, R, div_by_zero
   );
endinterface

// File: rtl/intdiv_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, MSB first.
// Produces Q = floor(A/B) and R = A mod B; B == 0 short-circuits to a flagged result.
module intdiv_seq #(
   parameter int LOG_A = 64,
   parameter int LOG_B = 32
) (
   input logic         i_clk,
   input logic         i_rst_n,
   intdiv_seq_if.slave s_bus
);
   localparam int CW = (LOG_A > 1) ? $clog2(LOG_A) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [LOG_A-1:0] r_dividend;
   logic [LOG_B-1:0] r_divisor;
   logic [LOG_B-1:0] r_p;
   logic [LOG_A-1:0] r_q;
   logic [LOG_B-1:0] r_r;
   logic             r_dbz;
   logic [CW-1:0]    r_cnt;

   logic [LOG_B:0]   w_t;
   logic             w_ge;
   logic [LOG_B-1:0] w_diff;
   logic [LOG_B-1:0] w_pnext;

   // The difference is only kept when T >= B, where it is < B and fits in LOG_B bits,
   // so the carry bit of the subtraction never needs to be formed.
   assign w_t     = {r_p, r_dividend[LOG_A-1]};
   assign w_ge    = (w_t >= {1'b0, r_divisor});
   assign w_diff  = w_t[LOG_B-1:0] - r_divisor;
   assign w_pnext = w_ge ? w_diff : w_t[LOG_B-1:0];

   assign s_bus.in_ready    = (r_state == S_IDLE);
   assign s_bus.out_valid   = (r_state == S_DONE);
   assign s_bus.Q           = r_q;
   assign s_bus.R           = r_r;
   assign s_bus.div_by_zero = r_dbz;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_dividend <= '0;
         r_divisor  <= '0;
         r_p        <= '0;
         r_q        <= '0;
         r_r        <= '0;
         r_dbz      <= 1'b0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (s_bus.in_valid) begin
                  r_dividend <= s_bus.A;
                  r_divisor  <= s_bus.B;
                  r_p        <= '0;
                  r_cnt      <= CW'(LOG_A - 1);
                  if (s_bus.B == '0) begin
                     r_state <= S_DONE;
                     r_q     <= '1;
                     r_r     <= s_bus.A[LOG_B-1:0];
                     r_dbz   <= 1'b1;
                  end else begin
                     r_state <= S_CALC;
                     r_dbz   <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               r_p        <= w_pnext;
               r_q        <= {r_q[LOG_A-2:0], w_ge};
               r_dividend <= {r_dividend[LOG_A-2:0], 1'b0};
               if (r_cnt == '0) begin
                  r_state <= S_DONE;
                  r_r     <= w_pnext;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DONE: begin
               if (s_bus.out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_intdiv_seq.sv
// Directed checks of an 8/4-bit divider plus a randomised 64/32-bit scoreboard run.
// Latency is counted with the accepting edge as edge 1.
module tb_intdiv_seq;
   localparam int NRAND = 300;

   typedef struct packed {
      logic [63:0] a;
      logic [31:0] b;
   } op_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   intdiv_seq_if #(.LOG_A(8),  .LOG_B(4))  b8 ();
   intdiv_seq_if #(.LOG_A(64), .LOG_B(32)) b64 ();

   intdiv_seq #(.LOG_A(8), .LOG_B(4)) dut8 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .s_bus   (b8)
   );

   intdiv_seq #(.LOG_A(64), .LOG_B(32)) dut64 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .s_bus   (b64)
   );

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while the divider is idle; returns at the negedge after acceptance.
   task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b);
      b8.in_valid = 1'b1;
      b8.A        = a;
      b8.B        = b;
      @(negedge clk);
      b8.in_valid = 1'b0;
      b8.A        = '0;
      b8.B        = '0;
   endtask

   task automatic waitResult(inout int edges);
      while (b8.out_valid !== 1'b1 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic consume(input string tag);
      b8.out_ready = 1'b1;
      @(negedge clk);
      b8.out_ready = 1'b0;
      checkOutput({tag, ".idle"}, {b8.in_ready, b8.out_valid}, 2'b10);
   endtask

   task automatic runOp8(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                         input int eedges);
      int edges;
      applyStimulus(a, b);
      edges = 1;
      waitResult(edges);
      checkOutput({tag, ".lat"}, edges, eedges);
      checkOutput({tag, ".Q"}, b8.Q, eq);
      checkOutput({tag, ".R"}, b8.R, er);
      checkOutput({tag, ".dbz"}, b8.div_by_zero, edbz);
      consume(tag);
   endtask

   initial begin
      op_t         pend[$];
      op_t         cur;
      op_t         nxt;
      logic [127:0] recon;
      int          edges;
      int          issued;
      int          done;
      int          cyc;

      b8.in_valid   = 1'b0;
      b8.A          = '0;
      b8.B          = '0;
      b8.out_ready  = 1'b0;
      b64.in_valid  = 1'b0;
      b64.A         = '0;
      b64.B         = '0;
      b64.out_ready = 1'b0;

      $display("[TB] reset");
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset8", {b8.in_ready, b8.out_valid, b8.Q, b8.R, b8.div_by_zero},
                  {1'b1, 1'b0, 8'd0, 4'd0, 1'b0});
      checkOutput("reset64", {b64.in_ready, b64.out_valid, b64.Q, b64.R, b64.div_by_zero},
                  {1'b1, 1'b0, 64'd0, 32'd0, 1'b0});
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] directed 8/4 operations");
      runOp8("t1_200_7", 8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9);
      runOp8("t2_255_1", 8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9);
      runOp8("t2_5_9",   8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 9);
      runOp8("t2_0_15",  8'd0,   4'd15, 8'd0,   4'd0, 1'b0, 9);
      runOp8("t2_255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9);
      runOp8("t3_13_0",  8'd13,  4'd0,  8'hFF,  4'hD, 1'b1, 1);
      runOp8("t3_200_7", 8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9);

      $display("[TB] ignored operands and held result");
      applyStimulus(8'd150, 4'd11);
      edges = 1;
      repeat (3) begin
         b8.in_valid = 1'b1;
         b8.A        = 8'd99;
         b8.B        = 4'd2;
         @(negedge clk);
         edges++;
         checkOutput("t4.busy", b8.in_ready, 1'b0);
      end
      b8.in_valid = 1'b0;
      waitResult(edges);
      checkOutput("t4.lat", edges, 9);
      b8.in_valid = 1'b1;
      b8.A        = 8'd3;
      b8.B        = 4'd0;
      repeat (5) begin
         @(negedge clk);
         checkOutput("t4.hold", {b8.in_ready, b8.out_valid, b8.Q, b8.R, b8.div_by_zero},
                     {1'b0, 1'b1, 8'd13, 4'd7, 1'b0});
      end
      b8.in_valid = 1'b0;
      consume("t4");
      runOp8("t4_77_5", 8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 9);

      $display("[TB] reset during calculation");
      applyStimulus(8'd200, 4'd7);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("t5.reset", {b8.in_ready, b8.out_valid, b8.Q, b8.R, b8.div_by_zero},
                  {1'b1, 1'b0, 8'd0, 4'd0, 1'b0});
      repeat (10) @(negedge clk);
      checkOutput("t5.noresult", b8.out_valid, 1'b0);
      runOp8("t5_100_3", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9);

      $display("[TB] random 64/32 operations");
      issued = 0;
      done   = 0;
      cyc    = 0;
      while (done < NRAND && cyc < 40000) begin
         @(negedge clk);
         cyc++;
         if (b64.out_valid === 1'b1 && $urandom_range(0, 3) != 0) begin
            b64.out_ready = 1'b1;
            if (pend.size() == 0) begin
               checkOutput("r64.spurious", 1'b1, 1'b0);
            end else begin
               cur   = pend.pop_front();
               recon = 128'(b64.Q) * 128'(cur.b) + 128'(b64.R);
               checkOutput("r64.Q", b64.Q, cur.a / 64'(cur.b));
               checkOutput("r64.R", b64.R, 32'(cur.a % 64'(cur.b)));
               checkOutput("r64.QBR", recon, 128'(cur.a));
               checkOutput("r64.RltB", b64.R < cur.b, 1'b1);
               checkOutput("r64.dbz", b64.div_by_zero, 1'b0);
            end
            done++;
         end else begin
            b64.out_ready = (b64.out_valid === 1'b1) ? 1'b0 : 1'($urandom_range(0, 1));
         end
         if (b64.in_ready === 1'b1) begin
            if (issued < NRAND) begin
               if (issued == 0) begin
                  nxt.a = 64'h8000_0000_0000_0000;
                  nxt.b = 32'd12289;
               end else begin
                  nxt.a = {$urandom(), $urandom()};
                  nxt.b = (issued % 7 == 0) ? 32'hFFFF_FFFF : $urandom();
                  if (nxt.b == 32'd0) nxt.b = 32'd1;
               end
               b64.in_valid = 1'b1;
               b64.A        = nxt.a;
               b64.B        = nxt.b;
               pend.push_back(nxt);
               issued++;
            end else begin
               b64.in_valid = 1'b0;
            end
         end
      end
      b64.out_ready = 1'b0;
      b64.in_valid  = 1'b0;
      checkOutput("r64.count", done, NRAND);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
